// File: rtl/param_rom_stream_scheduler.sv
// rtl/param_rom_stream_scheduler.sv - replays a registered parameter ROM as a valid/ready stream
// Credits count ROM reads in flight plus buffered beats so the output FIFO never overflows.
module param_rom_stream_scheduler #(
  parameter int DATA_WIDTH  = 512,
  parameter int OUT_DEPTH   = 32,
  parameter int ROM_LATENCY = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int PASS_WIDTH  = 16,
  parameter int ADDR_WIDTH  = $clog2(OUT_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [PASS_WIDTH-1:0] num_passes,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_ce,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_ready,
  output logic                  data_out_last
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(FIFO_DEPTH + ROM_LATENCY + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(OUT_DEPTH - 1);

  generate
    if (FIFO_DEPTH < ROM_LATENCY + 1) begin : g_depth_check
      $error("FIFO_DEPTH must be >= ROM_LATENCY+1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                  state;
  logic [PASS_WIDTH-1:0]   passes;
  logic [PASS_WIDTH-1:0]   pass_cnt;
  logic [ROM_LATENCY-1:0]  tag_v;
  logic [ROM_LATENCY-1:0]  tag_last;
  logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]   mem_last;
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [CW-1:0]           count;
  logic [SW-1:0]           inflight;
  logic                    push;
  logic                    pop;
  logic                    issue;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < ROM_LATENCY; i++) inflight = inflight + SW'(tag_v[i]);
  end

  assign push           = tag_v[ROM_LATENCY-1];
  assign data_out_valid = (count != '0);
  assign pop            = data_out_valid & data_out_ready;
  assign issue          = (state == RUN) && ((inflight + SW'(count)) < SW'(FIFO_DEPTH));
  assign data_out       = mem[rd_ptr];
  assign data_out_last  = data_out_valid & mem_last[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      rom_ce   <= 1'b0;
      rom_addr <= '0;
      passes   <= '0;
      pass_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (num_passes != '0) begin
            state    <= RUN;
            busy     <= 1'b1;
            rom_ce   <= 1'b1;
            passes   <= num_passes;
            pass_cnt <= '0;
            rom_addr <= '0;
          end else begin
            done <= 1'b1;
          end
        end
        RUN: if (issue) begin
          if (rom_addr == LAST_ADDR) begin
            rom_addr <= '0;
            if (pass_cnt == passes - PASS_WIDTH'(1)) state <= DRAIN;
            else pass_cnt <= pass_cnt + PASS_WIDTH'(1);
          end else begin
            rom_addr <= rom_addr + ADDR_WIDTH'(1);
          end
        end
        DRAIN: begin
          // Finish on the edge that retires the final beat so done follows it by one cycle.
          if (inflight == '0 && (count == '0 || (count == CW'(1) && pop))) begin
            state  <= IDLE;
            busy   <= 1'b0;
            rom_ce <= 1'b0;
            done   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag pipe mirrors the ROM's read latency; it shifts every cycle because the ROM never stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v    <= '0;
      tag_last <= '0;
    end else begin
      tag_v[0]    <= issue;
      tag_last[0] <= issue && (rom_addr == LAST_ADDR);
      for (int i = 1; i < ROM_LATENCY; i++) begin
        tag_v[i]    <= tag_v[i-1];
        tag_last[i] <= tag_last[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      mem_last <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr]      <= rom_q;
        mem_last[wr_ptr] <= tag_last[ROM_LATENCY-1];
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

endmodule
